// File: rtl/fp_result_buffer.sv
// Result FIFO for the FP multiplier: entries appear one cycle after push, and there is no fall-through path.
// in_ready is not-full only, so a pop does not free space until the next cycle; also keeps sticky flags and a saturating exception counter.
module fp_result_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_product,
    input  logic                   in_overflow,
    input  logic                   in_infinity,
    input  logic                   in_nan,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_product,
    output logic [2:0]             out_flags,
    output logic [$clog2(DEPTH):0] level,
    output logic [2:0]             sticky_flags,
    output logic [CNT_W-1:0]       exc_count,
    input  logic                   clear_status
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [34:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [2:0]       sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_base;
    logic [2:0]       in_flags;
    logic             push, pop;

    always_comb begin
        in_flags  = {in_nan, in_infinity, in_overflow};
        in_ready  = (level_q != LVL_W'(DEPTH));
        out_valid = (level_q != '0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // Clear is applied first so a same-cycle flagged push survives it.
        sticky_d = clear_status ? 3'b000 : sticky_q;
        cnt_base = clear_status ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (push) begin
            sticky_d = sticky_d | in_flags;
            if ((|in_flags) && !(&cnt_base)) begin
                cnt_d = cnt_base + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            sticky_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset; validity is tracked by level_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_flags, in_product};
        end
    end

    always_comb begin
        out_product  = out_valid ? mem_q[rd_ptr_q][31:0]  : 32'h0;
        out_flags    = out_valid ? mem_q[rd_ptr_q][34:32] : 3'b000;
        level        = level_q;
        sticky_flags = sticky_q;
        exc_count    = cnt_q;
    end

endmodule

// File: tb/tb_fp_result_buffer.sv
// Scoreboard bench for fp_result_buffer; a second instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_fp_result_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_product;
    logic        in_overflow, in_infinity, in_nan;
    logic        out_ready;
    logic        clear_status;

    logic        in_ready, out_valid;
    logic [31:0] out_product;
    logic [2:0]  out_flags;
    logic [2:0]  level;
    logic [2:0]  sticky_flags;
    logic [7:0]  exc_count;

    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_product;
    logic [2:0]  s_out_flags;
    logic [2:0]  s_level;
    logic [2:0]  s_sticky_flags;
    logic [1:0]  s_exc_count;

    int          n_checks = 0;
    int          n_errors = 0;
    int          mlevel   = 0;
    logic [2:0]  msticky  = 3'b000;
    int          mcnt     = 0;
    int          mcnt2    = 0;
    logic [34:0] sb [$];

    fp_result_buffer #(.DEPTH(DEPTH), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_product(in_product), .in_overflow(in_overflow),
        .in_infinity(in_infinity), .in_nan(in_nan),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_flags(out_flags),
        .level(level), .sticky_flags(sticky_flags),
        .exc_count(exc_count), .clear_status(clear_status)
    );

    fp_result_buffer #(.DEPTH(DEPTH), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_product(in_product), .in_overflow(in_overflow),
        .in_infinity(in_infinity), .in_nan(in_nan),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_product(s_out_product), .out_flags(s_out_flags),
        .level(s_level), .sticky_flags(s_sticky_flags),
        .exc_count(s_exc_count), .clear_status(clear_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] p, input logic [2:0] f, input logic rdy);
        in_valid    = v;
        in_product  = p;
        in_nan      = f[2];
        in_infinity = f[1];
        in_overflow = f[0];
        out_ready   = rdy;
    endtask

    // Model the coming edge from the current inputs, compare any pop, then advance.
    task automatic cycle();
        logic        push, pop;
        logic [34:0] exp;
        logic [2:0]  f;
        f    = {in_nan, in_infinity, in_overflow};
        push = in_valid && (mlevel < DEPTH);
        pop  = out_ready && (mlevel > 0);
        if (in_valid) check("in_ready", in_ready, mlevel < DEPTH);
        if (pop) begin
            exp = sb.pop_front();
            check("out_valid", out_valid, 1'b1);
            check("out_product", out_product, exp[31:0]);
            check("out_flags", out_flags, exp[34:32]);
        end
        if (clear_status) begin
            msticky = 3'b000;
            mcnt    = 0;
            mcnt2   = 0;
        end
        if (push) begin
            sb.push_back({f, in_product});
            msticky = msticky | f;
            if (|f) begin
                if (mcnt < 255) mcnt++;
                if (mcnt2 < 3) mcnt2++;
            end
        end
        mlevel = mlevel + int'(push) - int'(pop);
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_level"}, level, mlevel);
        check({tag, "_sticky"}, sticky_flags, msticky);
        check({tag, "_exc"}, exc_count, mcnt);
        check({tag, "_exc_sat"}, s_exc_count, mcnt2);
    endtask

    task automatic drain();
        drive(1'b0, 32'h0, 3'b000, 1'b1);
        while (mlevel > 0) cycle();
        out_ready = 1'b0;
        check("drain_level", level, 0);
        check("drain_out_valid", out_valid, 1'b0);
    endtask

    logic [31:0] fill_vals [4];

    initial begin
        fill_vals[0] = 32'h3F800000;
        fill_vals[1] = 32'h40000000;
        fill_vals[2] = 32'h40400000;
        fill_vals[3] = 32'h40800000;

        reset        = 1'b0;
        clear_status = 1'b0;
        drive(1'b0, 32'h0, 3'b000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_level", level, 0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sticky", sticky_flags, 0);
        check("rst_exc", exc_count, 0);
        check("rst_out_product", out_product, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single pass with one-cycle latency.
        drive(1'b1, 32'h40C00000, 3'b000, 1'b0);
        cycle();
        drive(1'b0, 32'h0, 3'b000, 1'b0);
        check("single_out_valid", out_valid, 1'b1);
        check("single_out_product", out_product, 32'h40C00000);
        check("single_level", level, 1);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        check("single_level_after", level, 0);

        // Fill, overfill attempt, ordered drain.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, fill_vals[i], 3'b000, 1'b0);
            cycle();
        end
        check("full_in_ready", in_ready, 1'b0);
        check("full_level", level, 4);
        drive(1'b1, 32'h40A00000, 3'b000, 1'b0);
        cycle();
        check("overfill_level", level, 4);
        drain();

        // Pointer wrap with concurrent push/pop.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h41000000 + 32'(i), 3'b000, 1'b1);
            cycle();
        end
        drain();

        // Full with simultaneous push and pop: pop only.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, fill_vals[i] ^ 32'h00F00000, 3'b000, 1'b0);
            cycle();
        end
        drive(1'b1, 32'hDEADBEEF, 3'b000, 1'b1);
        cycle();
        check("fullpp_level", level, 3);
        check("fullpp_in_ready", in_ready, 1'b1);
        drive(1'b0, 32'h0, 3'b000, 1'b1);
        cycle();
        drive(1'b1, 32'h42000000, 3'b000, 1'b1);
        cycle();
        check("pp_level2", level, 2);
        drain();

        // Status and clear ordering.
        drive(1'b1, 32'h7F800000, 3'b010, 1'b1);
        cycle();
        drive(1'b1, 32'h7FC00000, 3'b100, 1'b1);
        cycle();
        drive(1'b1, 32'h3F800000, 3'b000, 1'b1);
        cycle();
        check_status("stat");
        check("stat_sticky_const", sticky_flags, 3'b110);
        check("stat_exc_const", exc_count, 2);
        clear_status = 1'b1;
        drive(1'b1, 32'h7F7FFFFF, 3'b001, 1'b1);
        cycle();
        clear_status = 1'b0;
        check_status("clr");
        check("clr_sticky_const", sticky_flags, 3'b001);
        drain();

        // Saturation on the narrow counter.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'hFF800000, 3'b011, 1'b1);
            cycle();
        end
        check_status("sat");
        check("sat_exc_const", s_exc_count, 2'd3);
        drain();

        // Asynchronous reset between edges.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h40E00000 + 32'(i), 3'b000, 1'b0);
            cycle();
        end
        drive(1'b0, 32'h0, 3'b000, 1'b0);
        check("pre_arst_level", level, 3);
        #2;
        reset = 1'b0;
        #1;
        sb.delete();
        mlevel  = 0;
        msticky = 3'b000;
        mcnt    = 0;
        mcnt2   = 0;
        check("arst_level", level, 0);
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_out_product", out_product, 0);
        check_status("arst");
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 32'h12345678, 3'b101, 1'b0);
        cycle();
        drive(1'b0, 32'h0, 3'b000, 1'b0);
        check("post_arst_out_product", out_product, 32'h12345678);
        check("post_arst_out_flags", out_flags, 3'b101);
        check_status("post_arst");
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
